load_store_unit: RTL
====================

# load_store_unit

Load/store unit between the pipeline's memory stage and the word-addressed `dataMemory`. Accepts one byte, halfword or word request at a time over a valid/ready handshake and converts byte addresses to word addresses. Performs read-modify-write for sub-word stores and extracts and sign- or zero-extends sub-word loads. Returns a single-cycle response pulse carrying load data or a fault flag.

## Interface
- No parameters.
- `clock` in 1: rising-edge clock shared with `dataMemory`.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (always faults).
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: request rejected, no memory access made.
- `mem_address` out 32: word address, `{2'b00, addr[31:2]}`.
- `mem_writeData` out 32: word to store.
- `mem_memWrite` out 1: memory commits the write at the rising edge where this is high.
- `mem_memRead` out 1: memory drives `mem_readData` combinationally while this is high.
- `mem_readData` in 32: word from memory.

## Operation
- Handshake: a request is accepted at a rising edge with `req_valid && req_ready`. All request fields are latched into internal registers at that edge. `resp_valid` has no back-pressure, so the consumer must take it in the same cycle it is high.
- Byte lanes are little-endian. The selected byte is `addr[1:0]*8`. The selected half is `addr[1]*16`.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE, accept a load → READ.
  - IDLE, accept a word store → WRITE.
  - IDLE, accept a byte or half store → READ (the read half of the read-modify-write).
  - IDLE, accept a fault → RESP, with `resp_fault`=1.
  - READ: drive `mem_memRead`=1 and `mem_address`. At the end of the cycle, latch `mem_readData`. Then go to RESP for a load, or to WRITE for a sub-word store.
  - WRITE: drive `mem_memWrite`=1 and `mem_writeData`. For a sub-word store, `mem_writeData` is the latched word with only the target lane(s) replaced. Then go to RESP.
  - RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- `mem_memRead` and `mem_memWrite` are never high in the same cycle. Both are 0 in IDLE and RESP.
- Load extraction: byte → bit 7 replicated (or zeros if unsigned). Half → bit 15 replicated (or zeros if unsigned). Word → passed through unchanged; `req_unsigned` is ignored.
- Fault conditions: `req_size`=11, or misalignment (see Configuration). A faulted request makes no memory access.

## Timing
- Reset values (asserted asynchronously, held while `reset`=0):
  - state IDLE;
  - `req_ready`=1;
  - `resp_valid`, `resp_fault`, `resp_rdata`, `mem_address`, `mem_writeData`, `mem_memWrite`, `mem_memRead` all 0.
- Latency, counted from the accept edge at cycle 0:
  - load: `resp_valid` in cycle 2;
  - word store: cycle 2;
  - sub-word store: cycle 3;
  - fault: cycle 1.
- Throughput: one request per latency+1 cycles. `req_ready` returns to 1 in the cycle after the RESP cycle.
- Reset during any state aborts the operation immediately. `mem_memWrite` drops asynchronously, so a read-modify-write interrupted in READ leaves memory unchanged. No `resp_valid` is issued for the aborted request.
- `req_valid` held high while `req_ready`=0 is ignored. The request is accepted only at the first edge where IDLE is reached.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - a half access with `addr[0]`=1 faults;
  - a word access with `addr[1:0]`≠0 faults;
  - `resp_fault`=1 and there is no memory traffic.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - offending low address bits are cleared (half: `addr[0]`; word: `addr[1:0]`);
  - the access proceeds aligned and never faults for misalignment;
  - `req_size`=11 still faults.

## Test plan
- Word store `0xE0000000` to byte address `0x1C`, then word load from `0x1C`:
  - store: `mem_address`=7 with `mem_memWrite` pulse;
  - load: `resp_rdata`=`0xE0000000`, `resp_valid` in cycle 2 after accept.
- Word store `0x11223344` to `0x18`, then byte store `0xAA` to `0x19`:
  - the byte store issues one READ cycle then one WRITE cycle with `mem_writeData`=`0x1122AA44`;
  - a following word load returns `0x1122AA44`.
- Byte load from `0x19` (memory word `0x1122AA44`):
  - signed: `resp_rdata`=`0xFFFFFFAA`;
  - unsigned: `0x000000AA`.
- Halfword load from `0x1A` (memory word `0x1122AA44`):
  - signed and unsigned both: `resp_rdata`=`0x00001122`.
- Word load from `0x1A`:
  - with `LSU_MISALIGN_TRAP_EN`: `resp_fault`=1, `resp_rdata`=0, `resp_valid` in cycle 1, `mem_memRead` never asserted;
  - without it: reads word 6, `resp_fault`=0.
- Byte store to `0x18`, with `reset` pulled low during the READ cycle:
  - all outputs go to their reset values immediately;
  - no `mem_memWrite` pulse, and word 6 is unchanged on a subsequent load;
  - `req_ready`=1 once reset is released.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// slave: the unit's view. master: the pipeline/memory view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word requests to a word-addressed data memory.
// Sub-word stores use read-modify-write; sub-word loads are sign/zero-extended.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently aligned down.
module load_store_unit (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] rword_q;

  logic        accept;
  logic        fault_new;
  logic [31:0] addr_new;
  logic [31:0] merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = bus.req_valid && (state_q == StIdle);

  // Classify the incoming request: fault detection and address alignment.
  always_comb begin
    fault_new = (bus.req_size == 2'b11);
    addr_new  = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    if (bus.req_size == 2'b01 && bus.req_addr[0]) fault_new = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) fault_new = 1'b1;
`else
    // Misaligned accesses proceed on the enclosing aligned unit.
    if (bus.req_size == 2'b01) addr_new[0] = 1'b0;
    if (bus.req_size == 2'b10) addr_new[1:0] = 2'b00;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (fault_new) state_d = StResp;
          else if (bus.req_write && bus.req_size == 2'b10) state_d = StWrite;
          else state_d = StRead;
        end
      end
      StRead:  state_d = write_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched request fields and the word captured during READ.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      fault_q    <= 1'b0;
      rword_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= bus.req_write;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        addr_q     <= addr_new;
        wdata_q    <= bus.req_wdata;
        fault_q    <= fault_new;
      end
      if (state_q == StRead) rword_q <= bus.mem_readData;
    end
  end

  // Store word: replace only the addressed lane(s) of the word read back.
  always_comb begin
    merged = rword_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Load extraction and sign/zero extension from the captured word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = rword_q[7:0];
      2'd1:    ld_byte = rword_q[15:8];
      2'd2:    ld_byte = rword_q[23:16];
      default: ld_byte = rword_q[31:24];
    endcase
    ld_half = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~unsigned_q & ld_half[15]}}, ld_half};
      default: ld_ext = rword_q;
    endcase
  end

  // Outputs decode from state only, so reset clears them asynchronously.
  always_comb begin
    bus.req_ready     = (state_q == StIdle);
    bus.mem_memRead   = (state_q == StRead);
    bus.mem_memWrite  = (state_q == StWrite);
    bus.mem_address   = 32'h0;
    bus.mem_writeData = 32'h0;
    bus.resp_valid    = (state_q == StResp);
    bus.resp_fault    = (state_q == StResp) && fault_q;
    bus.resp_rdata    = 32'h0;
    if (state_q == StRead || state_q == StWrite) bus.mem_address = {2'b00, addr_q[31:2]};
    if (state_q == StWrite) bus.mem_writeData = merged;
    if (state_q == StResp && !fault_q && !write_q) bus.resp_rdata = ld_ext;
  end

endmodule
